// File: rtl/ser_pkg.sv
// Shared definitions for the serial transmit/receive pair: FSM states and line levels.
package ser_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } ser_state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/ser_tx_if.sv
// Producer-side word handshake plus the serial line and frame status of the transmitter.
interface ser_tx_if #(
   parameter int WIDTH = 8
) ();

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             tx;
   logic             busy;
   logic             done;

   modport master (
      output in_data, in_valid,
      input  in_ready, tx, busy, done
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, tx, busy, done
   );

endinterface

// File: rtl/ser_baud_tick.sv
// Bit-period counter: tick_o is high on the last of every DIV cycles; clear_i holds it at zero.
module ser_baud_tick #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   output logic tick_o
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ser_tx.sv
// UART-style transmitter: start bit, WIDTH data bits LSB first, stop bit, DIV cycles per bit.
// Defining SER_TX_PARITY_EN inserts an even-parity bit between the last data bit and the stop bit.
module ser_tx
   import ser_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input logic     clk,
   input logic     rst,
   ser_tx_if.slave bus
);

   localparam int            IW       = $clog2(WIDTH) + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   ser_state_e       state_q;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic [IW-1:0]    idx_q;
   logic             tx_q;
   logic             busy_q;
   logic             done_q;
   logic             tick;
`ifdef SER_TX_PARITY_EN
   logic             par_q;
`endif

   // Counter is held cleared in IDLE so the start bit always lasts a full DIV cycles.
   ser_baud_tick #(.DIV(DIV)) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clear_i (state_q == IDLE),
      .tick_o  (tick)
   );

   assign shift_d = shift_q >> 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= LINE_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SER_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  shift_q <= bus.in_data;
                  idx_q   <= '0;
                  tx_q    <= START_BIT;
                  busy_q  <= 1'b1;
                  state_q <= START;
`ifdef SER_TX_PARITY_EN
                  par_q   <= 1'b0;
`endif
               end
            end
            START: begin
               if (tick) begin
                  tx_q    <= shift_q[0];
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  shift_q <= shift_d;
                  idx_q   <= idx_q + IW'(1);
`ifdef SER_TX_PARITY_EN
                  par_q   <= par_q ^ shift_q[0];
`endif
                  if (idx_q == LAST_IDX) begin
`ifdef SER_TX_PARITY_EN
                     tx_q    <= par_q ^ shift_q[0];
                     state_q <= PARITY;
`else
                     tx_q    <= STOP_BIT;
                     state_q <= STOP;
`endif
                  end else begin
                     tx_q <= shift_d[0];
                  end
               end
            end
`ifdef SER_TX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  tx_q    <= STOP_BIT;
                  state_q <= STOP;
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  tx_q    <= LINE_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               tx_q    <= LINE_IDLE;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready = (state_q == IDLE);
   assign bus.tx       = tx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule
